// File: rtl/dma_req_responder.sv
// Channel-side DMA request responder.
// Queues translated DMA requests, meters the matching data stream beat by
// beat (one registered xfer pulse per beat) and emits a completion record
// for every request flagged last. Requests complete strictly in order.
module dma_req_responder #(
  parameter int ADDR_BITS  = 64,
  parameter int LEN_BITS   = 28,
  parameter int PID_BITS   = 6,
  parameter int DEST_BITS  = 4,
  parameter int BEAT_BYTES = 64,
  parameter int QDEPTH     = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_req_valid,
  output logic                 s_req_ready,
  input  logic [ADDR_BITS-1:0] s_req_paddr,
  input  logic [LEN_BITS-1:0]  s_req_len,
  input  logic                 s_req_last,
  input  logic [PID_BITS-1:0]  s_req_pid,
  input  logic [DEST_BITS-1:0] s_req_dest,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic                 xfer,
  output logic                 m_done_valid,
  input  logic                 m_done_ready,
  output logic [PID_BITS-1:0]  m_done_pid,
  output logic [DEST_BITS-1:0] m_done_dest,
  output logic                 busy,
  output logic                 err
);

  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int BEAT_W     = LEN_BITS - BEAT_SHIFT + 1;
  localparam int PTR_W      = $clog2(QDEPTH);

  typedef struct packed {
    logic [BEAT_W-1:0]    beats;
    logic                 last;
    logic [PID_BITS-1:0]  pid;
    logic [DEST_BITS-1:0] dest;
  } req_t;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  // ---------------------------------------------------------------- FIFO
  req_t             mem [QDEPTH];
  req_t             in_req;
  req_t             head;
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [LEN_BITS:0] len_round;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             run;

  // The physical address travels with the request but is never interpreted
  // here; the low rounding bits are discarded by the beat shift.
  logic unused_bits;
  assign unused_bits = ^{s_req_paddr, len_round[BEAT_SHIFT-1:0]};

  // Round the byte length up to whole beats at enqueue time.
  assign len_round    = {1'b0, s_req_len} + (LEN_BITS + 1)'(BEAT_BYTES - 1);
  assign in_req.beats = len_round[LEN_BITS:BEAT_SHIFT];
  assign in_req.last  = s_req_last;
  assign in_req.pid   = s_req_pid;
  assign in_req.dest  = s_req_dest;

  // Full is taken from the registered pointers, so a same-cycle pop never
  // opens a slot for an enqueue in that cycle.
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  assign s_req_ready = run & ~full;
  assign push        = s_req_valid & s_req_ready;

  // Request storage write port.
  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, so clearing them empties the queue.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= in_req;
  end

  // Queue pointers and the post-reset enable for request acceptance.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ----------------------------------------------------------------- FSM
  state_t               state, state_d;
  logic [BEAT_W-1:0]    beats_left, beats_d;
  logic                 cur_last, last_d;
  logic [PID_BITS-1:0]  cur_pid, pid_d;
  logic [DEST_BITS-1:0] cur_dest, dest_d;
  logic                 err_d;
  logic                 tready;
  logic                 done_valid;

  // Next-state, head load, beat accounting and tlast checking.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state;
    beats_d    = beats_left;
    last_d     = cur_last;
    pid_d      = cur_pid;
    dest_d     = cur_dest;
    err_d      = err;
    pop        = 1'b0;
    tready     = 1'b0;
    done_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          beats_d = head.beats;
          last_d  = head.last;
          pid_d   = head.pid;
          dest_d  = head.dest;
          if (head.beats == '0) begin
            if (head.last) state_d = DONE;
            else           pop     = 1'b1;
          end else begin
            state_d = XFER;
          end
        end
      end
      XFER: begin
        tready = 1'b1;
        if (s_axis_tvalid) begin
          beats_d = beats_left - BEAT_W'(1);
          if (beats_left == BEAT_W'(1)) begin
            if (s_axis_tlast != cur_last) err_d = 1'b1;
            if (cur_last) begin
              state_d = DONE;
            end else begin
              pop     = 1'b1;
              state_d = IDLE;
            end
          end else if (s_axis_tlast) begin
            err_d = 1'b1;
          end
        end
      end
      DONE: begin
        done_valid = 1'b1;
        if (m_done_ready) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, current-request registers, sticky error and xfer pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      beats_left <= '0;
      cur_last   <= 1'b0;
      cur_pid    <= '0;
      cur_dest   <= '0;
      err        <= 1'b0;
      xfer       <= 1'b0;
    end else begin
      state      <= state_d;
      beats_left <= beats_d;
      cur_last   <= last_d;
      cur_pid    <= pid_d;
      cur_dest   <= dest_d;
      err        <= err_d;
      xfer       <= s_axis_tvalid & tready;
    end
  end

  assign s_axis_tready = tready;
  assign m_done_valid  = done_valid;
  assign m_done_pid    = cur_pid;
  assign m_done_dest   = cur_dest;
  assign busy          = ~empty | (state != IDLE);

endmodule

// File: doc/dma_req_responder.md
Name: dma_req_responder

Overview:
- Far end of the per-vFPGA DMA request channel: accepts translated DMA requests (physical address, length, last, pid, dest) issued by the MMU region toward a host or card channel.
- Meters the matching data stream beat by beat and returns one transfer pulse per beat, feeding the MMU credit logic's xfer input.
- Emits a completion record for every request flagged last, forming the source of the rd/wr done metadata.
- One instance per channel and direction; used as the channel-side model in region-level benches and as the beat accountant in the shell.

Parameters:
- ADDR_BITS, 64, physical address width
- LEN_BITS, 28, request length width (bytes)
- PID_BITS, 6, process id width
- DEST_BITS, 4, destination stream id width
- BEAT_BYTES, 64, bytes per data beat (power of two)
- QDEPTH, 8, outstanding request FIFO depth (power of two)

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- s_req_valid  in  1  request valid
- s_req_ready  out  1  request accepted when valid & ready
- s_req_paddr  in  ADDR_BITS  physical address (carried, not interpreted)
- s_req_len  in  LEN_BITS  length in bytes
- s_req_last  in  1  final segment of a user transfer
- s_req_pid  in  PID_BITS  process id
- s_req_dest  in  DEST_BITS  destination id
- s_axis_tvalid  in  1  data beat valid
- s_axis_tready  out  1  data beat ready
- s_axis_tlast  in  1  data last flag (checked only)
- xfer  out  1  one-cycle pulse per completed beat
- m_done_valid  out  1  completion valid
- m_done_ready  in  1  completion accepted
- m_done_pid  out  PID_BITS  completed pid
- m_done_dest  out  DEST_BITS  completed dest
- busy  out  1  FIFO non-empty or FSM not IDLE
- err  out  1  sticky tlast mismatch

Behaviour:
- Reset (async assert, sync deassert in aclk domain): FIFO emptied, FSM IDLE, counters 0; s_req_ready=0 during reset and 1 from the first cycle after; s_axis_tready=0, xfer=0, m_done_valid=0, m_done_pid/dest=0, busy=0, err=0.
- Reset mid-operation drops all outstanding requests and any pending completion; no partial completion is emitted.
- Request FIFO:
  - s_req_ready = !full.
  - Full is evaluated before any same-cycle pop; no enqueue while full even if a pop occurs that cycle.
  - Beat count is computed at enqueue: beats = (len + BEAT_BYTES-1) >> log2(BEAT_BYTES), width LEN_BITS-log2(BEAT_BYTES)+1.
- FSM states IDLE, XFER, DONE:
  - IDLE: if FIFO non-empty, load head into beats_left/pid/dest/last. beats=0 -> go to DONE if last, else pop and stay IDLE (zero-beat requests take one cycle each). beats>0 -> XFER. One cycle of latency from FIFO non-empty to tready.
  - XFER: s_axis_tready=1. Each tvalid&tready decrements beats_left.
  - On the final beat (beats_left==1): check tlast; tlast!=last sets err (sticky, cleared only by reset). Then go to DONE if last, else pop and go to IDLE.
  - tlast on a non-final beat also sets err. Data is never dropped.
  - DONE: s_axis_tready=0. m_done_valid=1 with pid/dest held stable until m_done_ready. On handshake, pop and go to IDLE. m_done_valid may precede m_done_ready.
- xfer is registered: pulses exactly one cycle after each beat handshake; back-to-back beats give back-to-back pulses.
- Requests complete strictly in order. No address-based reordering.

Test Plan:
- Request len=256, last=1, pid=3, dest=1; 4 beats with tvalid held, tlast on beat 4 -> tready high 4 cycles, 4 consecutive xfer pulses each lagging one cycle, m_done_valid with pid=3 dest=1, err=0.
- len=100, last=0 then len=64, last=1 pid=5 -> 2 beats then 1 beat; single completion pid=5; no completion for the first request.
- Enqueue 8 requests of len=64 with no data -> s_req_ready=0 after the 8th; after one beat plus done handshake, ready returns to 1.
- len=0, last=1, pid=7 -> completion pid=7 with zero tready cycles and zero xfer pulses.
- m_done_ready held low for 10 cycles -> done fields stable and tready=0 throughout; next request is not started until the handshake.
- tlast asserted on beat 2 of a 4-beat request -> err=1, remains set; then assert aresetn=0 mid-XFER -> all outputs return to their reset values immediately, busy=0.
